// File: rtl/opr_phase_sequencer.sv
// Instruction phase sequencer: issues one-hot ck/stb sub-phases until the
// active decoder returns done, flagging sequences that overrun the last phase.
module opr_phase_sequencer #(
  parameter int NPHASE = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       done,
  input  logic       pause,
  output logic       ck1,
  output logic       stb1,
  output logic       ck2,
  output logic       stb2,
  output logic       ck3,
  output logic       stb3,
  output logic       ck4,
  output logic       stb4,
  output logic       ck5,
  output logic       stb5,
  output logic       ck6,
  output logic       stb6,
  output logic       busy,
  output logic [3:0] phase,
  output logic       timeout,
  output logic       err
);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  localparam logic [3:0] LAST_PHASE = 4'(2 * NPHASE);

  state_t     state;
  logic [5:0] ck_v;
  logic [5:0] stb_v;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      phase   <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
      err     <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !pause) begin
            state <= S_RUN;
            phase <= 4'd1;
            busy  <= 1'b1;
            err   <= 1'b0;
          end
        end
        S_RUN: begin
          // Pause freezes the sub-phase; done is discarded until release.
          if (!pause) begin
            if (done) begin
              if (start) begin
                phase <= 4'd1;
              end else begin
                state <= S_IDLE;
                phase <= '0;
                busy  <= 1'b0;
              end
            end else if (phase == LAST_PHASE) begin
              state   <= S_IDLE;
              phase   <= '0;
              busy    <= 1'b0;
              timeout <= 1'b1;
              err     <= 1'b1;
            end else begin
              phase <= phase + 4'd1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          phase <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Phases beyond NPHASE are never decoded, so their outputs stay tied low.
  for (genvar g = 0; g < 6; g++) begin : g_decode
    if (g < NPHASE) begin : g_used
      assign ck_v[g]  = !pause && (phase == 4'(2 * g + 1));
      assign stb_v[g] = !pause && (phase == 4'(2 * g + 2));
    end else begin : g_unused
      assign ck_v[g]  = 1'b0;
      assign stb_v[g] = 1'b0;
    end
  end

  assign ck1  = ck_v[0];
  assign ck2  = ck_v[1];
  assign ck3  = ck_v[2];
  assign ck4  = ck_v[3];
  assign ck5  = ck_v[4];
  assign ck6  = ck_v[5];
  assign stb1 = stb_v[0];
  assign stb2 = stb_v[1];
  assign stb3 = stb_v[2];
  assign stb4 = stb_v[3];
  assign stb5 = stb_v[4];
  assign stb6 = stb_v[5];

endmodule

// File: tb/tb_opr_phase_sequencer.sv
// Directed bench for opr_phase_sequencer: a six-phase and a four-phase instance
// are driven together and compared against a per-instance reference model.
module tb_opr_phase_sequencer;

  typedef struct {
    int ph;
    bit to;
    bit er;
  } exp_t;

  logic clk = 1'b0;
  logic reset, start, done, pause, done4;

  logic [5:0] ck_a, stb_a, ck_b, stb_b;
  logic       busy_a, busy_b, to_a, to_b, err_a, err_b;
  logic [3:0] phase_a, phase_b;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int busy_cnt = 0;
  int to_cyc = -1;
  int mark = 0;
  bit hi_unused = 1'b0;

  int m_ph[2];
  bit m_to[2];
  bit m_er[2];
  exp_t q_a[$];
  exp_t q_b[$];

  always #5 clk = ~clk;

  opr_phase_sequencer #(.NPHASE(6)) dut (
    .clk(clk), .reset(reset), .start(start), .done(done), .pause(pause),
    .ck1(ck_a[0]), .stb1(stb_a[0]), .ck2(ck_a[1]), .stb2(stb_a[1]),
    .ck3(ck_a[2]), .stb3(stb_a[2]), .ck4(ck_a[3]), .stb4(stb_a[3]),
    .ck5(ck_a[4]), .stb5(stb_a[4]), .ck6(ck_a[5]), .stb6(stb_a[5]),
    .busy(busy_a), .phase(phase_a), .timeout(to_a), .err(err_a)
  );

  opr_phase_sequencer #(.NPHASE(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .done(done4), .pause(pause),
    .ck1(ck_b[0]), .stb1(stb_b[0]), .ck2(ck_b[1]), .stb2(stb_b[1]),
    .ck3(ck_b[2]), .stb3(stb_b[2]), .ck4(ck_b[3]), .stb4(stb_b[3]),
    .ck5(ck_b[4]), .stb5(stb_b[4]), .ck6(ck_b[5]), .stb6(stb_b[5]),
    .busy(busy_b), .phase(phase_b), .timeout(to_b), .err(err_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] exp_vec(input int ph, input int np, input bit p, input bit odd);
    logic [5:0] v;
    v = '0;
    if (!p && ph >= 1 && ph <= 2 * np && ((ph % 2) == 1) == odd)
      v = 6'(1) << ((ph - 1) / 2);
    return v;
  endfunction

  function automatic void model_step(input int k, input int np, input bit s, input bit d, input bit p);
    m_to[k] = 1'b0;
    if (p) return;
    if (m_ph[k] == 0) begin
      if (s) begin
        m_ph[k] = 1;
        m_er[k] = 1'b0;
      end
    end else if (d) begin
      m_ph[k] = s ? 1 : 0;
    end else if (m_ph[k] == 2 * np) begin
      m_ph[k] = 0;
      m_to[k] = 1'b1;
      m_er[k] = 1'b1;
    end else begin
      m_ph[k] = m_ph[k] + 1;
    end
  endfunction

  task automatic cycle(input bit s, input bit d, input bit p, input bit r);
    exp_t e;
    start = s; done = d; pause = p; reset = r;
    #1;
    chk("ck_a", 32'(ck_a), 32'(exp_vec(m_ph[0], 6, p, 1'b1)));
    chk("stb_a", 32'(stb_a), 32'(exp_vec(m_ph[0], 6, p, 1'b0)));
    chk("ck_b", 32'(ck_b), 32'(exp_vec(m_ph[1], 4, p, 1'b1)));
    chk("stb_b", 32'(stb_b), 32'(exp_vec(m_ph[1], 4, p, 1'b0)));
    hi_unused |= ck_b[4] | ck_b[5] | stb_b[4] | stb_b[5];
    if (r) begin
      for (int k = 0; k < 2; k++) begin
        m_ph[k] = 0; m_to[k] = 1'b0; m_er[k] = 1'b0;
      end
    end else begin
      model_step(0, 6, s, d, p);
      model_step(1, 4, s, 1'b0, p);
    end
    q_a.push_back('{m_ph[0], m_to[0], m_er[0]});
    q_b.push_back('{m_ph[1], m_to[1], m_er[1]});
    @(posedge clk);
    #1;
    cyc++;
    e = q_a.pop_front();
    chk("phase_a", 32'(phase_a), 32'(e.ph));
    chk("busy_a", 32'(busy_a), 32'(e.ph != 0));
    chk("timeout_a", 32'(to_a), 32'(e.to));
    chk("err_a", 32'(err_a), 32'(e.er));
    e = q_b.pop_front();
    chk("phase_b", 32'(phase_b), 32'(e.ph));
    chk("busy_b", 32'(busy_b), 32'(e.ph != 0));
    chk("timeout_b", 32'(to_b), 32'(e.to));
    chk("err_b", 32'(err_b), 32'(e.er));
    busy_cnt += int'(busy_a);
    if (to_a) to_cyc = cyc;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; done = 1'b0; pause = 1'b0; done4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      m_ph[k] = 0; m_to[k] = 1'b0; m_er[k] = 1'b0;
    end
    chk("rst_phase", 32'(phase_a), 32'd0);
    chk("rst_outs", 32'({ck_a, stb_a}), 32'd0);
    chk("rst_flags", 32'({busy_a, to_a, err_a}), 32'd0);

    // Reset mid-sequence at stb2
    cycle(1, 0, 0, 0);
    repeat (3) cycle(0, 0, 0, 0);
    chk("at_stb2", 32'(stb_a), 32'h2);
    cycle(0, 0, 0, 1);
    chk("post_rst_phase", 32'(phase_a), 32'd0);
    cycle(0, 0, 0, 0);

    // Short instruction ending on ck2
    busy_cnt = 0;
    cycle(1, 0, 0, 0);
    repeat (2) cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    chk("short_busy_cycles", 32'(busy_cnt), 32'd3);
    chk("short_err", 32'(err_a), 32'd0);
    repeat (8) cycle(0, 0, 0, 0);

    // Back-to-back: done on ck3 with start, second ends on ck4
    cycle(1, 0, 0, 0);
    repeat (4) cycle(0, 0, 0, 0);
    busy_cnt = 0;
    cycle(1, 1, 0, 0);
    chk("b2b_ck1", 32'(phase_a), 32'd1);
    repeat (6) cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    chk("b2b_busy_cycles", 32'(busy_cnt), 32'd7);
    repeat (8) cycle(0, 0, 0, 0);

    // Pause at stb1 for 4 cycles, done during pause is discarded
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 1, 1, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 0);
    chk("pause_held", 32'(phase_a), 32'd2);
    cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    repeat (8) cycle(0, 0, 0, 0);
    cycle(1, 0, 1, 0);
    chk("idle_pause_blocks", 32'(phase_a), 32'd0);

    // Overrun with done held low
    mark = cyc;
    to_cyc = -1;
    cycle(1, 0, 0, 0);
    repeat (12) cycle(0, 0, 0, 0);
    chk("overrun_cycle", 32'(to_cyc - mark), 32'd13);
    chk("overrun_err", 32'(err_a), 32'd1);
    cycle(1, 0, 0, 0);
    chk("err_cleared", 32'(err_a), 32'd0);
    cycle(0, 1, 0, 0);
    repeat (10) cycle(0, 0, 0, 0);

    chk("unused_phases_low", 32'(hi_unused), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
